// File: rtl/sfm_tcdm_serializer.sv
// Splits each wide TCDM request into narrow beats, skipping beats with no byte enables,
// and reassembles in-order narrow read responses into one wide response.
module sfm_tcdm_serializer #(
    parameter int WIDE_DW   = 256,
    parameter int NARROW_DW = 64,
    parameter int ADDR_W    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    output logic                     busy_o,
    input  logic                     w_req_i,
    output logic                     w_gnt_o,
    input  logic [ADDR_W-1:0]        w_add_i,
    input  logic                     w_wen_i,
    input  logic [WIDE_DW/8-1:0]     w_be_i,
    input  logic [WIDE_DW-1:0]       w_data_i,
    output logic [WIDE_DW-1:0]       w_r_data_o,
    output logic                     w_r_valid_o,
    output logic                     n_req_o,
    output logic [ADDR_W-1:0]        n_add_o,
    output logic                     n_wen_o,
    output logic [NARROW_DW/8-1:0]   n_be_o,
    output logic [NARROW_DW-1:0]     n_data_o,
    input  logic                     n_gnt_i,
    input  logic [NARROW_DW-1:0]     n_r_data_i,
    input  logic                     n_r_valid_i
);

    localparam int N_BEATS = WIDE_DW / NARROW_DW;
    localparam int NBE     = NARROW_DW / 8;
    localparam int WBE     = WIDE_DW / 8;
    localparam int PTR_W   = $clog2(N_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

    function automatic logic [N_BEATS-1:0] f_beat_mask(input logic [WBE-1:0] be);
        logic [N_BEATS-1:0] m;
        for (int k = 0; k < N_BEATS; k++) m[k] = |be[k*NBE +: NBE];
        return m;
    endfunction

    // Returns {found, index} of the lowest enabled beat at or above 'from'.
    function automatic logic [PTR_W:0] f_next(input logic [N_BEATS-1:0] m, input logic [PTR_W:0] from);
        logic [PTR_W:0] r;
        r = '0;
        for (int k = N_BEATS - 1; k >= 0; k--)
            if (m[k] && (k >= int'(from))) r = {1'b1, PTR_W'(k)};
        return r;
    endfunction

    state_t                 r_state, w_state_nxt;
    logic                   r_busy;
    logic [ADDR_W-1:0]      r_add;
    logic                   r_wen;
    logic [WBE-1:0]         r_be;
    logic [WIDE_DW-1:0]     r_data;
    logic [PTR_W-1:0]       r_ip, r_rp;
    logic                   r_rdone;
    logic [WIDE_DW-1:0]     r_buf, r_rdata;
    logic                   r_n_req, r_n_wen;
    logic [ADDR_W-1:0]      r_n_add;
    logic [NBE-1:0]         r_n_be;
    logic [NARROW_DW-1:0]   r_n_data;

    logic [N_BEATS-1:0]     w_mask_in, w_mask;
    logic [PTR_W:0]         w_first, w_ip_nxt, w_rp_nxt;
    logic                   w_gnt, w_collect, w_rdone_now;

    assign w_mask_in   = f_beat_mask(w_be_i);
    assign w_mask      = f_beat_mask(r_be);
    assign w_first     = f_next(w_mask_in, '0);
    assign w_ip_nxt    = f_next(w_mask, {1'b0, r_ip} + 1'b1);
    assign w_rp_nxt    = f_next(w_mask, {1'b0, r_rp} + 1'b1);
    assign w_collect   = (r_state == S_ISSUE || r_state == S_DRAIN) && r_wen && n_r_valid_i && !r_rdone;
    assign w_rdone_now = r_rdone || (w_collect && !w_rp_nxt[PTR_W]);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt = w_req_i & ~clear_i;
                if (w_gnt) begin
                    if (w_first[PTR_W])  w_state_nxt = S_ISSUE;
                    else if (w_wen_i)    w_state_nxt = S_RESP;
                end
            end
            S_ISSUE: begin
                if (n_gnt_i && !w_ip_nxt[PTR_W]) begin
                    if (!r_wen)           w_state_nxt = S_IDLE;
                    else if (w_rdone_now) w_state_nxt = S_RESP;
                    else                  w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: if (w_rdone_now) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (clear_i) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_add    <= '0;
            r_wen    <= 1'b0;
            r_be     <= '0;
            r_data   <= '0;
            r_ip     <= '0;
            r_rp     <= '0;
            r_rdone  <= 1'b0;
            r_buf    <= '0;
            r_rdata  <= '0;
            r_n_req  <= 1'b0;
            r_n_wen  <= 1'b0;
            r_n_add  <= '0;
            r_n_be   <= '0;
            r_n_data <= '0;
        end else if (clear_i) begin
            r_ip    <= '0;
            r_rp    <= '0;
            r_rdone <= 1'b0;
            r_buf   <= '0;
            r_n_req <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_gnt) begin
                r_add   <= w_add_i;
                r_wen   <= w_wen_i;
                r_be    <= w_be_i;
                r_data  <= w_data_i;
                r_buf   <= '0;
                r_rdone <= 1'b0;
                r_ip    <= w_first[PTR_W-1:0];
                r_rp    <= w_first[PTR_W-1:0];
                // First beat is loaded straight from the inputs so it issues the cycle after accept.
                if (w_first[PTR_W]) begin
                    r_n_req  <= 1'b1;
                    r_n_wen  <= w_wen_i;
                    r_n_add  <= w_add_i + ADDR_W'(int'(w_first[PTR_W-1:0]) * NBE);
                    r_n_be   <= w_be_i[int'(w_first[PTR_W-1:0])*NBE +: NBE];
                    r_n_data <= w_data_i[int'(w_first[PTR_W-1:0])*NARROW_DW +: NARROW_DW];
                end
            end
            if (r_state == S_ISSUE && n_gnt_i) begin
                if (w_ip_nxt[PTR_W]) begin
                    r_ip     <= w_ip_nxt[PTR_W-1:0];
                    r_n_add  <= r_add + ADDR_W'(int'(w_ip_nxt[PTR_W-1:0]) * NBE);
                    r_n_be   <= r_be[int'(w_ip_nxt[PTR_W-1:0])*NBE +: NBE];
                    r_n_data <= r_data[int'(w_ip_nxt[PTR_W-1:0])*NARROW_DW +: NARROW_DW];
                end else begin
                    r_n_req  <= 1'b0;
                end
            end
            if (w_collect) begin
                r_buf[int'(r_rp)*NARROW_DW +: NARROW_DW] <= n_r_data_i;
                if (w_rp_nxt[PTR_W]) r_rp    <= w_rp_nxt[PTR_W-1:0];
                else                 r_rdone <= 1'b1;
            end
            // Buffer is zeroed on the next accept, so the response is latched to hold it.
            if (r_state == S_RESP) r_rdata <= r_buf;
        end
    end

    assign busy_o      = r_busy;
    assign w_gnt_o     = w_gnt;
    assign w_r_valid_o = (r_state == S_RESP);
    assign w_r_data_o  = w_r_valid_o ? r_buf : r_rdata;
    assign n_req_o     = r_n_req;
    assign n_add_o     = r_n_add;
    assign n_wen_o     = r_n_wen;
    assign n_be_o      = r_n_be;
    assign n_data_o    = r_n_data;

endmodule

// File: tb/tb_sfm_tcdm_serializer.sv
// Scoreboard bench for sfm_tcdm_serializer: expected narrow beats and wide responses are
// queued when a wide request is driven and checked by negedge monitors.
module tb_sfm_tcdm_serializer;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear_i;
    logic           busy_o;
    logic           w_req_i;
    logic           w_gnt_o;
    logic [31:0]    w_add_i;
    logic           w_wen_i;
    logic [31:0]    w_be_i;
    logic [255:0]   w_data_i;
    logic [255:0]   w_r_data_o;
    logic           w_r_valid_o;
    logic           n_req_o;
    logic [31:0]    n_add_o;
    logic           n_wen_o;
    logic [7:0]     n_be_o;
    logic [63:0]    n_data_o;
    logic           n_gnt_i;
    logic [63:0]    n_r_data_i;
    logic           n_r_valid_i;

    logic           spur_rv;
    int             cyc = 0;
    int             n_total = 0;
    int             n_pass = 0;

    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [7:0]  be;
        logic [63:0] data;
    } nreq_t;

    typedef struct {
        logic [255:0] data;
        int           cyc;
    } wresp_t;

    nreq_t  nq[$];
    wresp_t rq[$];

    sfm_tcdm_serializer #(.WIDE_DW(256), .NARROW_DW(64), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .busy_o(busy_o),
        .w_req_i(w_req_i), .w_gnt_o(w_gnt_o), .w_add_i(w_add_i), .w_wen_i(w_wen_i),
        .w_be_i(w_be_i), .w_data_i(w_data_i), .w_r_data_o(w_r_data_o), .w_r_valid_o(w_r_valid_o),
        .n_req_o(n_req_o), .n_add_o(n_add_o), .n_wen_o(n_wen_o), .n_be_o(n_be_o),
        .n_data_o(n_data_o), .n_gnt_i(n_gnt_i), .n_r_data_i(n_r_data_i), .n_r_valid_i(n_r_valid_i)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = 8'hA0 + 8'(a[7:3]);
        return {8{b}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: in-order responses one cycle after each granted read; spur_rv injects a stray response.
    initial begin
        logic        hs, sp;
        logic [31:0] a;
        n_r_valid_i = 1'b0;
        n_r_data_i  = '0;
        forever begin
            @(negedge clk);
            hs = n_req_o & n_gnt_i & n_wen_o;
            a  = n_add_o;
            sp = spur_rv;
            @(posedge clk);
            #1;
            n_r_valid_i = hs | sp;
            n_r_data_i  = hs ? mem_word(a) : (sp ? 64'hDEAD_BEEF_DEAD_BEEF : 64'h0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (n_req_o && n_gnt_i) begin
                if (nq.size() == 0) check("unexp_nreq", n_req_o, 0);
                else begin
                    nreq_t e;
                    e = nq.pop_front();
                    check("n_add", n_add_o, e.add);
                    check("n_wen", n_wen_o, e.wen);
                    check("n_be", n_be_o, e.be);
                    check("n_data", n_data_o, e.data);
                end
            end
            if (w_r_valid_o) begin
                if (rq.size() == 0) check("unexp_rvalid", w_r_valid_o, 0);
                else begin
                    wresp_t r;
                    r = rq.pop_front();
                    check("r_data", w_r_data_o, r.data);
                    check("r_cycle", cyc, r.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] add, input logic wen, input logic [31:0] be,
                        input logic [255:0] data, input int lat);
        nreq_t        e;
        wresp_t       r;
        logic [255:0] exp_d;
        w_req_i  = 1'b1;
        w_add_i  = add;
        w_wen_i  = wen;
        w_be_i   = be;
        w_data_i = data;
        exp_d    = '0;
        for (int k = 0; k < 4; k++) begin
            if (be[k*8 +: 8] != 8'h00) begin
                e.add  = add + 32'(8 * k);
                e.wen  = wen;
                e.be   = be[k*8 +: 8];
                e.data = data[k*64 +: 64];
                nq.push_back(e);
                if (wen) exp_d[k*64 +: 64] = mem_word(e.add);
            end
        end
        if (wen && lat >= 0) begin
            r.data = exp_d;
            r.cyc  = cyc + lat;
            rq.push_back(r);
        end
        #1;
        check("w_gnt", w_gnt_o, 1);
        step();
        w_req_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (!busy_o && nq.size() == 0 && rq.size() == 0) done = 1'b1;
            else step();
        end
        check(tag, done, 1);
    endtask

    initial begin
        logic [255:0] d;
        rst_n    = 1'b0;
        clear_i  = 1'b0;
        w_req_i  = 1'b0;
        w_add_i  = '0;
        w_wen_i  = 1'b0;
        w_be_i   = '0;
        w_data_i = '0;
        n_gnt_i  = 1'b1;
        spur_rv  = 1'b0;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();

        repeat (2) step();
        check("rst_busy", busy_o, 0);
        check("rst_nreq", n_req_o, 0);
        check("rst_rvalid", w_r_valid_o, 0);
        check("rst_rdata", w_r_data_o, 0);
        rst_n = 1'b1;
        step();

        // Full read: beats at 0x100..0x118, response six cycles after accept.
        send(32'h100, 1'b1, 32'hFFFF_FFFF, d, 6);
        wait_idle("full_read_done");

        // Sparse write: only beats 1 and 3, partial byte enables.
        send(32'h180, 1'b0, 32'hC300_5A00, ~d, -1);
        wait_idle("sparse_write_done");

        // Zero-enable read answers with zero data one cycle later; zero-enable write does nothing.
        send(32'h300, 1'b1, 32'h0, d, 1);
        wait_idle("zero_read_done");
        send(32'h320, 1'b0, 32'h0, d, -1);
        check("zero_write_busy", busy_o, 0);
        check("zero_write_nreq", n_req_o, 0);
        wait_idle("zero_write_done");

        // Grant backpressure on beat 2 for three cycles.
        send(32'h400, 1'b1, 32'hFFFF_FFFF, d, 9);
        step();
        step();
        n_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) n_gnt_i = 1'b1;
            check("stall_req", n_req_o, 1);
            check("stall_add", n_add_o, 32'h410);
            check("stall_be", n_be_o, 8'hFF);
            check("stall_data", n_data_o, d[128 +: 64]);
            if (i < 3) step();
        end
        wait_idle("stall_read_done");

        // Clear during DRAIN, stray response in IDLE, then a fresh sparse read.
        send(32'h100, 1'b1, 32'hFFFF_FFFF, d, -1);
        repeat (4) step();
        check("drain_busy", busy_o, 1);
        check("drain_nreq", n_req_o, 0);
        clear_i = 1'b1;
        spur_rv = 1'b1;
        step();
        clear_i = 1'b0;
        spur_rv = 1'b0;
        check("clear_busy", busy_o, 0);
        send(32'h240, 1'b1, 32'h00FF_00FF, d, 4);
        wait_idle("post_clear_read_done");

        // Asynchronous reset while issuing.
        send(32'h500, 1'b1, 32'hFFFF_FFFF, d, 6);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_nreq", n_req_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_rvalid", w_r_valid_o, 0);
        nq.delete();
        rq.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        send(32'h140, 1'b1, 32'hF0F0_0F0F, d, 6);
        wait_idle("post_reset_read_done");

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
